// File: rtl/count_sequencer.sv
// Step/load sequencer for an external up/down counter: arbitrates load, manual
// pulses and a prescaled auto tick, and applies bound blocking or wrap-around.
module count_sequencer #(
    parameter int BITS     = 8,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            up_p,
    input  logic            down_p,
    input  logic            run,
    input  logic            dir,
    input  logic            wrap,
    input  logic [BITS-1:0] limit,
    input  logic [BITS-1:0] sw_d,
    input  logic [BITS-1:0] count,
    output logic            cnt_en,
    output logic            cnt_up,
    output logic            cnt_load,
    output logic [BITS-1:0] cnt_d,
    output logic [1:0]      state,
    output logic            at_limit
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10,
        LOAD = 2'b11
    } state_t;

    state_t        st;
    logic [PW-1:0] pre;

    logic up_blk, dn_blk, manual, tick, req, req_up, blk, dir_blk;

    always_comb begin
        up_blk  = count >= limit;
        dn_blk  = count == '0;
        manual  = up_p | down_p;
        tick    = (st == RUN) && run && (pre == TICK_LAST);
        // any manual pulse, even an illegal double press, swallows the tick
        req     = (up_p ^ down_p) || (!manual && tick);
        req_up  = manual ? up_p : dir;
        blk     = req_up ? up_blk : dn_blk;
        dir_blk = dir ? up_blk : dn_blk;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st       <= IDLE;
            pre      <= '0;
            cnt_en   <= 1'b0;
            cnt_up   <= 1'b0;
            cnt_load <= 1'b0;
            cnt_d    <= '0;
            at_limit <= 1'b0;
        end else begin
            cnt_en   <= 1'b0;
            cnt_up   <= 1'b0;
            cnt_load <= 1'b0;
            cnt_d    <= '0;
            at_limit <= up_blk | dn_blk;
            pre      <= '0;
            if (load) begin
                st       <= LOAD;
                cnt_en   <= 1'b1;
                cnt_load <= 1'b1;
                cnt_d    <= sw_d;
            end else if (st == LOAD) begin
                st <= run ? RUN : IDLE;
            end else begin
                if (req) begin
                    if (!blk) begin
                        cnt_en <= 1'b1;
                        cnt_up <= req_up;
                    end else if (wrap) begin
                        cnt_en   <= 1'b1;
                        cnt_load <= 1'b1;
                        cnt_d    <= req_up ? '0 : limit;
                    end
                end
                case (st)
                    IDLE: if (run) st <= RUN;
                    RUN: begin
                        if (!run)
                            st <= IDLE;
                        else if (tick && !manual && blk && !wrap)
                            st <= HALT;
                        else
                            pre <= tick ? '0 : pre + 1'b1;
                    end
                    HALT: begin
                        if (!run)
                            st <= IDLE;
                        else if (!dir_blk || wrap)
                            st <= RUN;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    assign state = st;
endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: an external counter fed back into the DUT, a
// cycle-level rule model compared every cycle, directed scenarios, random run.
module tb_count_sequencer;
    localparam int TD = 4;

    logic       clk, reset_n, load, up_p, down_p, run, dir, wrap;
    logic [7:0] limit, sw_d, count;
    logic       cnt_en, cnt_up, cnt_load, at_limit;
    logic [7:0] cnt_d;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    count_sequencer #(.BITS(8), .TICK_DIV(TD)) dut (
        .clk(clk), .reset_n(reset_n), .load(load), .up_p(up_p), .down_p(down_p),
        .run(run), .dir(dir), .wrap(wrap), .limit(limit), .sw_d(sw_d),
        .count(count), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_load(cnt_load),
        .cnt_d(cnt_d), .state(state), .at_limit(at_limit)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // external counter that the sequencer drives
    logic [7:0] cnt = 8'd0;
    assign count = cnt;
    always @(posedge clk)
        if (cnt_en) cnt <= cnt_load ? cnt_d : (cnt_up ? cnt + 8'd1 : cnt - 8'd1);

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // rule model: state 0=IDLE 1=RUN 2=HALT 3=LOAD, prescaler as an int
    int mst = 0, mpre = 0;
    int e_en, e_up, e_ld, e_d, e_st, e_al;

    always @(posedge clk) begin
        int  c, lim, ns;
        bit  up_b, dn_b, man, tick, rq, rq_up, blk, halt;
        c = cnt; lim = limit;
        e_en = 0; e_up = 0; e_ld = 0; e_d = 0;
        if (!reset_n) begin
            mst = 0; mpre = 0; e_st = 0; e_al = 0;
        end else begin
            up_b = c >= lim;
            dn_b = c == 0;
            e_al = up_b || dn_b;
            ns = mst; halt = 0;
            if (load) begin
                ns = 3; e_en = 1; e_ld = 1; e_d = sw_d;
            end else if (mst == 3) begin
                ns = run ? 1 : 0;
            end else begin
                man   = up_p || down_p;
                tick  = (mst == 1) && run && (mpre == TD - 1);
                rq    = (man && (up_p != down_p)) || (!man && tick);
                rq_up = man ? up_p : dir;
                blk   = rq_up ? up_b : dn_b;
                if (rq) begin
                    if (!blk) begin
                        e_en = 1; e_up = rq_up;
                    end else if (wrap) begin
                        e_en = 1; e_ld = 1; e_d = rq_up ? 0 : lim;
                    end else if (!man) halt = 1;
                end
                case (mst)
                    0: ns = run ? 1 : 0;
                    1: ns = !run ? 0 : (halt ? 2 : 1);
                    default: ns = !run ? 0 : (((dir ? !up_b : !dn_b) || wrap) ? 1 : 2);
                endcase
            end
            mpre = (mst == 1 && ns == 1) ? (mpre + 1) % TD : 0;
            mst  = ns;
            e_st = ns;
        end
        #1;
        chk("cnt_en", cnt_en, e_en);
        chk("cnt_up", cnt_up, e_up);
        chk("cnt_load", cnt_load, e_ld);
        chk("cnt_d", cnt_d, e_d);
        chk("state", state, e_st);
        chk("at_limit", at_limit, e_al);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k, c0;
        reset_n = 0; load = 0; up_p = 0; down_p = 0; run = 0; dir = 0; wrap = 0;
        limit = 8'd0; sw_d = 8'd0;
        #3;
        chk("rst_state", state, 0);
        chk("rst_en", cnt_en, 0);
        chk("rst_at_limit", at_limit, 0);
        cyc(2);
        reset_n = 1;

        // load 0x2A for three cycles
        load = 1; sw_d = 8'h2A;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("load_d", cnt_d, 8'h2A);
            chk("load_strobe", cnt_load & cnt_en, 1);
        end
        load = 0;
        cyc(1);
        chk("load_exit_idle", state, 0);
        chk("load_count", cnt, 42);

        // auto run up to limit 5 without wrap: ends in HALT
        limit = 8'd5; sw_d = 8'd3; load = 1;
        cyc(1);
        load = 0; run = 1; dir = 1; wrap = 0;
        k = 0;
        while (state != 2 && k < 40) begin cyc(1); k++; end
        chk("halt_reached", state, 2);
        chk("halt_count", cnt, 5);
        chk("halt_at_limit", at_limit, 1);

        // wrap on: next tick loads 0, then down at 0 loads limit
        wrap = 1;
        k = 0;
        while (!cnt_load && k < 20) begin cyc(1); k++; end
        chk("wrap_up_load", cnt_load, 1);
        chk("wrap_up_d", cnt_d, 0);
        dir = 0;
        cyc(1);
        chk("wrap_count0", cnt, 0);
        k = 0;
        while (!cnt_load && k < 20) begin cyc(1); k++; end
        chk("wrap_dn_load", cnt_load, 1);
        chk("wrap_dn_d", cnt_d, 5);

        // manual pulse on the tick cycle wins over a down tick
        wrap = 0; limit = 8'd200; sw_d = 8'd10; load = 1;
        cyc(1);
        load = 0; dir = 0;
        cyc(2);
        k = 0;
        while (!cnt_en && k < 20) begin cyc(1); k++; end
        chk("tick_seen", cnt_en, 1);
        cyc(3);
        up_p = 1; c0 = cnt;
        cyc(1);
        up_p = 0;
        chk("man_tick_up", cnt_up, 1);
        cyc(1);
        chk("man_tick_count", cnt, c0 + 1);
        up_p = 1; down_p = 1;
        cyc(1);
        up_p = 0; down_p = 0;
        chk("both_pulses_none", cnt_en, 0);

        // reset in the middle of LOAD
        load = 1; sw_d = 8'h55;
        cyc(2);
        #2 reset_n = 0;
        #1;
        chk("rst_mid_state", state, 0);
        chk("rst_mid_en", cnt_en, 0);
        chk("rst_mid_d", cnt_d, 0);
        load = 0; run = 0;
        cyc(2);
        reset_n = 1;

        // count above limit: up blocked, down still steps
        limit = 8'd100; wrap = 0; sw_d = 8'd200; load = 1;
        cyc(1);
        load = 0;
        cyc(1);
        up_p = 1;
        cyc(1);
        up_p = 0;
        chk("above_up_blocked", cnt_en, 0);
        cyc(1);
        chk("above_count", cnt, 200);
        down_p = 1;
        cyc(1);
        down_p = 0;
        cyc(1);
        chk("above_down", cnt, 199);

        // randomized traffic, checked every cycle by the model
        limit = 8'd12;
        for (int i = 0; i < 3000; i++) begin
            int r;
            reset_n = ($urandom % 500) != 0;
            load    = ($urandom % 40) == 0;
            sw_d    = 8'($urandom_range(0, 25));
            r       = $urandom % 20;
            up_p    = (r == 0) || (r == 2);
            down_p  = (r == 1) || (r == 2);
            if ($urandom % 30 == 0) run  = ~run;
            if ($urandom % 25 == 0) dir  = ~dir;
            if ($urandom % 40 == 0) wrap = ~wrap;
            if ($urandom % 60 == 0) limit = 8'($urandom_range(0, 20));
            cyc(1);
        end
        reset_n = 1; load = 0; up_p = 0; down_p = 0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
